// File: rtl/branch_pred_if.sv
// Lookup and resolve bus between the fetch/execute stages and the branch unit.
interface branch_pred_if #(
  parameter int unsigned XLEN = 32
);
  logic [XLEN-1:0] lk_pc;
  logic            lk_taken;
  logic            rs_valid;
  logic [XLEN-1:0] rs_pc;
  logic [2:0]      rs_funct3;
  logic [XLEN-1:0] rs_a;
  logic [XLEN-1:0] rs_b;
  logic            rs_pred;
  logic            rs_taken;
  logic            rs_mispred;
  logic            rs_err;

  modport master (
    output lk_pc, rs_valid, rs_pc, rs_funct3, rs_a, rs_b, rs_pred,
    input  lk_taken, rs_taken, rs_mispred, rs_err
  );

  modport slave (
    input  lk_pc, rs_valid, rs_pc, rs_funct3, rs_a, rs_b, rs_pred,
    output lk_taken, rs_taken, rs_mispred, rs_err
  );
endinterface

// File: rtl/branch_pred_unit.sv
// B-type branch resolution, 2-bit counter direction predictor and
// saturating branch/mispredict statistics.
module branch_pred_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned IDX_BITS   = 6,
  parameter int unsigned CNT_W      = 16,
  parameter logic [1:0]  INIT_STATE = 2'b01
) (
  input  logic             clk,
  input  logic             rst,
  branch_pred_if.slave     bus,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] stat_br,
  output logic [CNT_W-1:0] stat_mp
);

  localparam int unsigned DEPTH = 2 ** IDX_BITS;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]          table_q [DEPTH];
  logic [IDX_BITS-1:0] lk_idx;
  logic [IDX_BITS-1:0] rs_idx;

  logic [XLEN:0] diff;
  logic          eq;
  logic          ltu;
  logic          lt;
  logic          ovf;
  logic          legal;
  logic          cond;
  logic [1:0]    cur_ctr;
  logic [1:0]    nxt_ctr;
  logic          unused_pc_bits;

  assign lk_idx = bus.lk_pc[IDX_BITS+1:2];
  assign rs_idx = bus.rs_pc[IDX_BITS+1:2];
  assign unused_pc_bits = ^{bus.lk_pc[XLEN-1:IDX_BITS+2], bus.lk_pc[1:0],
                            bus.rs_pc[XLEN-1:IDX_BITS+2], bus.rs_pc[1:0]};

  // Zero-latency lookup; the table write lands after this edge, so reads see old data
  assign bus.lk_taken = table_q[lk_idx][1];

  // One subtractor serves all compares: borrow for unsigned, N xor V for signed
  assign diff = {1'b0, bus.rs_a} - {1'b0, bus.rs_b};
  assign eq   = (bus.rs_a == bus.rs_b);
  assign ltu  = diff[XLEN];
  assign ovf  = (bus.rs_a[XLEN-1] ^ bus.rs_b[XLEN-1]) & (bus.rs_a[XLEN-1] ^ diff[XLEN-1]);
  assign lt   = diff[XLEN-1] ^ ovf;

  always_comb begin
    legal = 1'b1;
    cond  = 1'b0;
    case (bus.rs_funct3)
      3'b000:  cond = eq;
      3'b001:  cond = ~eq;
      3'b100:  cond = lt;
      3'b101:  cond = ~lt;
      3'b110:  cond = ltu;
      3'b111:  cond = ~ltu;
      default: legal = 1'b0;
    endcase
  end

  assign bus.rs_taken   = bus.rs_valid & legal & cond;
  assign bus.rs_mispred = bus.rs_valid & legal & (bus.rs_taken != bus.rs_pred);
  assign bus.rs_err     = bus.rs_valid & ~legal;

  // Saturating counter step for the resolving entry
  always_comb begin
    cur_ctr = table_q[rs_idx];
    nxt_ctr = cur_ctr;
    if (cond) begin
      if (cur_ctr != 2'b11) nxt_ctr = cur_ctr + 2'd1;
    end else begin
      if (cur_ctr != 2'b00) nxt_ctr = cur_ctr - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) table_q[i] <= INIT_STATE;
    end else if (bus.rs_valid && legal) begin
      table_q[rs_idx] <= nxt_ctr;
    end
  end

  // Statistics: clear dominates increment, both hold at all-ones
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      stat_br <= '0;
      stat_mp <= '0;
    end else if (bus.rs_valid && legal) begin
      if (stat_br != CNT_MAX) stat_br <= stat_br + CNT_W'(1);
      if (bus.rs_mispred && (stat_mp != CNT_MAX)) stat_mp <= stat_mp + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_pred_unit.sv
// Self-checking bench for branch_pred_unit: compare vectors, directed
// training/hazard/stat sequences and a random run against a reference model.
module tb_branch_pred_unit;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 4;
  localparam int MAXC = 15;
  localparam int NENT = 64;

  logic             clk;
  logic             rst;
  logic             stat_clr;
  logic [CNT_W-1:0] stat_br;
  logic [CNT_W-1:0] stat_mp;

  branch_pred_if #(.XLEN(XLEN)) bif ();

  branch_pred_unit #(.XLEN(XLEN), .IDX_BITS(6), .CNT_W(CNT_W), .INIT_STATE(2'b01)) dut (
    .clk(clk), .rst(rst), .bus(bif.slave),
    .stat_clr(stat_clr), .stat_br(stat_br), .stat_mp(stat_mp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: counter value per entry and plain integer stats
  int m_tbl [NENT];
  int m_br;
  int m_mp;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic        exp_taken;
    logic        exp_err;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_legal(input logic [2:0] f3);
    return !(f3 == 3'b010 || f3 == 3'b011);
  endfunction

  function automatic bit m_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int idx(input logic [31:0] pc);
    return int'(pc[7:2]);
  endfunction

  task automatic drive(input logic v, input logic [31:0] pc, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b, input logic pred,
                       input logic [31:0] lkpc, input logic clr);
    bif.rs_valid  = v;
    bif.rs_pc     = pc;
    bif.rs_funct3 = f3;
    bif.rs_a      = a;
    bif.rs_b      = b;
    bif.rs_pred   = pred;
    bif.lk_pc     = lkpc;
    stat_clr      = clr;
  endtask

  task automatic check_comb();
    bit lg, t;
    lg = m_legal(bif.rs_funct3);
    t  = bif.rs_valid && lg && m_cond(bif.rs_funct3, bif.rs_a, bif.rs_b);
    check("rs_taken", 32'(bif.rs_taken), 32'(t));
    check("rs_err", 32'(bif.rs_err), 32'(bif.rs_valid && !lg));
    check("rs_mispred", 32'(bif.rs_mispred), 32'(bif.rs_valid && lg && (t != bif.rs_pred)));
    if (!rst) check("lk_taken", 32'(bif.lk_taken), 32'(m_tbl[idx(bif.lk_pc)] >= 2));
  endtask

  // Check combinational outputs, advance one edge, update model, check stats
  task automatic tick();
    bit lg, t;
    int e;
    #1;
    check_comb();
    lg = bif.rs_valid && m_legal(bif.rs_funct3);
    t  = m_cond(bif.rs_funct3, bif.rs_a, bif.rs_b);
    e  = idx(bif.rs_pc);
    @(posedge clk);
    #1;
    if (rst) begin
      for (int i = 0; i < NENT; i++) m_tbl[i] = 1;
      m_br = 0;
      m_mp = 0;
    end else begin
      if (lg) m_tbl[e] = t ? ((m_tbl[e] < 3) ? m_tbl[e] + 1 : 3) : ((m_tbl[e] > 0) ? m_tbl[e] - 1 : 0);
      if (stat_clr) begin
        m_br = 0;
        m_mp = 0;
      end else if (lg) begin
        if (m_br < MAXC) m_br++;
        if (t != bif.rs_pred && m_mp < MAXC) m_mp++;
      end
    end
    check("stat_br", 32'(stat_br), 32'(m_br));
    check("stat_mp", 32'(stat_mp), 32'(m_mp));
  endtask

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'h7fff_ffff;
      2: return 32'hffff_ffff;
      3: return 32'(($urandom_range(0, 3)));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    for (int i = 0; i < NENT; i++) m_tbl[i] = 1;
    m_br = 0;
    m_mp = 0;

    vecs[0]  = '{3'b100, 32'h8000_0000, 32'h0000_0002, 1'b1, 1'b0};
    vecs[1]  = '{3'b110, 32'h8000_0000, 32'h0000_0002, 1'b0, 1'b0};
    vecs[2]  = '{3'b101, 32'h8000_0000, 32'h0000_0002, 1'b0, 1'b0};
    vecs[3]  = '{3'b111, 32'h8000_0000, 32'h0000_0002, 1'b1, 1'b0};
    vecs[4]  = '{3'b000, 32'hffff_ffff, 32'hffff_ffff, 1'b1, 1'b0};
    vecs[5]  = '{3'b001, 32'hffff_ffff, 32'hffff_ffff, 1'b0, 1'b0};
    vecs[6]  = '{3'b010, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b1};
    vecs[7]  = '{3'b011, 32'h0000_0000, 32'h0000_0005, 1'b0, 1'b1};
    vecs[8]  = '{3'b000, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0};
    vecs[9]  = '{3'b100, 32'h0000_0005, 32'hffff_fffd, 1'b0, 1'b0};
    vecs[10] = '{3'b100, 32'h7fff_ffff, 32'h8000_0000, 1'b0, 1'b0};
    vecs[11] = '{3'b110, 32'h7fff_ffff, 32'h8000_0000, 1'b1, 1'b0};

    rst = 1'b1;
    drive(1'b0, 32'h0, 3'b000, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    tick();
    rst = 1'b0;

    // Reset state across the whole table
    for (int pc = 0; pc < 256; pc += 4) begin
      bif.lk_pc = 32'(pc);
      #1;
      check("reset_lk", 32'(bif.lk_taken), 32'h0);
    end
    check("reset_br", 32'(stat_br), 32'h0);
    check("reset_mp", 32'(stat_mp), 32'h0);

    // Compare vectors
    foreach (vecs[i]) begin
      drive(1'b1, 32'h80, vecs[i].f3, vecs[i].a, vecs[i].b, 1'b0, 32'h0, 1'b0);
      #1;
      check($sformatf("vec%0d_taken", i), 32'(bif.rs_taken), 32'(vecs[i].exp_taken));
      check($sformatf("vec%0d_err", i), 32'(bif.rs_err), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_mp", i), 32'(bif.rs_mispred), 32'(vecs[i].exp_taken));
      tick();
    end

    // Illegal funct3 leaves stats untouched
    drive(1'b0, 32'h0, 3'b000, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    begin
      logic [CNT_W-1:0] br0, mp0;
      br0 = stat_br;
      mp0 = stat_mp;
      drive(1'b1, 32'h20, 3'b010, 32'h1, 32'h1, 1'b1, 32'h20, 1'b0);
      tick();
      check("illegal_br", 32'(stat_br), 32'(br0));
      check("illegal_mp", 32'(stat_mp), 32'(mp0));
    end

    // Training, saturation, aliasing
    drive(1'b1, 32'h20, 3'b000, 32'h5, 32'h5, 1'b0, 32'h20, 1'b0);
    #1;
    check("train_mp", 32'(bif.rs_mispred), 32'h1);
    check("train_lk_before", 32'(bif.lk_taken), 32'h0);
    tick();
    drive(1'b0, 32'h0, 3'b000, 32'h0, 32'h0, 1'b0, 32'h20, 1'b0);
    #1;
    check("train_lk_after", 32'(bif.lk_taken), 32'h1);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h20, 3'b000, 32'h5, 32'h5, 1'b1, 32'h20, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 3'b000, 32'h0, 32'h0, 1'b0, 32'h120, 1'b0);
    #1;
    check("alias_lk", 32'(bif.lk_taken), 32'h1);
    drive(1'b1, 32'h20, 3'b000, 32'h5, 32'h6, 1'b1, 32'h20, 1'b0);
    tick();
    check("sat_nt1", 32'(bif.lk_taken), 32'h1);
    tick();
    check("sat_nt2", 32'(bif.lk_taken), 32'h0);

    // Same-cycle lookup/update hazard
    drive(1'b1, 32'h40, 3'b000, 32'h7, 32'h7, 1'b0, 32'h40, 1'b0);
    #1;
    check("hazard_same", 32'(bif.lk_taken), 32'h0);
    tick();
    drive(1'b0, 32'h0, 3'b000, 32'h0, 32'h0, 1'b0, 32'h40, 1'b0);
    #1;
    check("hazard_next", 32'(bif.lk_taken), 32'h1);

    // Stat saturation and clear priority
    drive(1'b0, 32'h0, 3'b000, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
    tick();
    check("clr_br", 32'(stat_br), 32'h0);
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 32'h300, 3'b000, 32'h1, 32'h1, 1'b0, 32'h0, 1'b0);
      tick();
    end
    check("sat_br", 32'(stat_br), 32'd15);
    check("sat_mp", 32'(stat_mp), 32'd15);
    drive(1'b1, 32'h300, 3'b000, 32'h1, 32'h1, 1'b0, 32'h0, 1'b1);
    tick();
    check("clrwin_br", 32'(stat_br), 32'h0);
    check("clrwin_mp", 32'(stat_mp), 32'h0);

    // Reset mid-training
    drive(1'b1, 32'h60, 3'b000, 32'h2, 32'h2, 1'b0, 32'h60, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, 32'h0, 3'b000, 32'h0, 32'h0, 1'b0, 32'h60, 1'b0);
    #1;
    check("midrst_lk", 32'(bif.lk_taken), 32'h0);
    check("midrst_br", 32'(stat_br), 32'h0);

    // Randomized run against the model
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] pc, lk;
      pc = 32'($urandom_range(0, 127) * 4 + $urandom_range(0, 3));
      lk = ($urandom_range(0, 3) == 0) ? pc : 32'($urandom_range(0, 511));
      drive(1'($urandom_range(0, 3) != 0), pc, 3'($urandom_range(0, 7)), rand_op(), rand_op(),
            1'($urandom_range(0, 1)), lk, 1'($urandom_range(0, 40) == 0));
      rst = ($urandom_range(0, 400) == 0);
      tick();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_pred_unit.md
Name: branch_pred_unit

Overview:
Branch resolution and dynamic prediction unit for the RISC-V core.
- Resolves all six B-type conditions (beq, bne, blt, bge, bltu, bgeu) at parametrised width XLEN.
- Predicts branch direction at fetch from a direct-mapped table of 2-bit saturating counters, trained at resolve.
- Keeps saturating performance counters for resolved branches and mispredictions.
- Sits beside the ALU in execute; the lookup side feeds the fetch stage's next-PC selection.

Parameters:
XLEN, 32, operand and PC width.
IDX_BITS, 6, table index width; table depth = 2**IDX_BITS entries.
CNT_W, 16, width of each performance counter.
INIT_STATE, 2'b01, counter value loaded on reset (weakly not-taken).

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous reset, active-high.
lk_pc  in  XLEN  fetch PC to predict.
lk_taken  out  1  predicted taken; combinational from table.
rs_valid  in  1  a branch is resolving this cycle.
rs_pc  in  XLEN  PC of the resolving branch.
rs_funct3  in  3  branch condition (000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu).
rs_a  in  XLEN  rs1 value.
rs_b  in  XLEN  rs2 value.
rs_pred  in  1  prediction originally issued for this branch.
rs_taken  out  1  actual outcome; combinational, 0 when rs_valid=0 or funct3 illegal.
rs_mispred  out  1  rs_valid & legal & (rs_taken != rs_pred); combinational.
rs_err  out  1  rs_valid & funct3 in {010, 011}; combinational.
stat_clr  in  1  synchronous clear of both stat counters.
stat_br  out  CNT_W  legal resolved branches, saturating.
stat_mp  out  CNT_W  mispredictions, saturating.

Behaviour:
- Reset: on a rising edge with rst=1, every table entry becomes INIT_STATE and stat_br = stat_mp = 0. rst overrides rs_valid and stat_clr in the same cycle, including reset asserted mid-training.
- Index mapping: entry index = pc[IDX_BITS+1:2]; pc[1:0] is ignored. PCs differing only above bit IDX_BITS+1 alias to the same entry; aliasing is accepted, there are no tags.
- Lookup: lk_taken = table[idx(lk_pc)][1]. Zero latency, read-before-write. A same-cycle update to the same entry is visible to lookup from the next cycle only.
- Comparison:
  - Signed compare for blt/bge uses the true signed result, i.e. N xor V of rs_a - rs_b, or an equivalent signed compare. It must be correct at overflow, e.g. 0x80000000 < 0x00000002 is true.
  - Unsigned compare uses the carry/borrow of the subtraction.
  - bge and bgeu are the exact complements of blt and bltu; bne is the complement of beq.
- Training: on a rising edge with rs_valid=1 and legal funct3, entry idx(rs_pc) updates:
  - taken: +1, saturating at 3.
  - not-taken: -1, saturating at 0.
  - Exactly one entry changes per cycle.
- Illegal funct3: rs_err=1, rs_taken=0, rs_mispred=0. No table update and no stat increment.
- Stats:
  - stat_br increments on each legal resolve.
  - stat_mp increments when rs_mispred=1.
  - Both hold at 2**CNT_W-1 (no wrap).
  - stat_clr=1 clears both; clear wins over a same-cycle increment.
- Idle: with rs_valid=0, no state changes apart from stat_clr.

Test Plan:
- Reset: after rst, lk_pc = 0, 4, ..., 252 all give lk_taken=0; stat_br = stat_mp = 0.
- Overflow compare: blt with rs_a=0x80000000, rs_b=2 -> rs_taken=1. bltu with the same operands -> 0. bge -> 0. bgeu -> 1. beq with rs_a=rs_b=0xffffffff -> 1.
- Training, saturation and aliasing:
  - Resolve pc=0x20 taken, rs_pred=0 -> rs_mispred=1; next cycle lk_pc=0x20 gives lk_taken=1.
  - Three further taken resolves keep the entry at 3; two not-taken resolves are then needed before lk_taken=0.
  - lk_pc=0x120 (aliases 0x20 with IDX_BITS=6) mirrors 0x20.
- Same-cycle hazard: lk_pc = rs_pc = 0x40, entry 01, taken resolve -> lk_taken=0 that cycle, 1 the next cycle.
- Illegal funct3=010 with rs_valid=1 -> rs_err=1, rs_mispred=0; table and stats unchanged.
- Stats:
  - With CNT_W=4: 20 legal mispredicted resolves -> stat_br = stat_mp = 15.
  - stat_clr together with rs_valid -> both 0.
  - rst asserted mid-sequence -> table back to INIT_STATE on the next edge.
